data_sram_responder: RTL and testbench
======================================

Name: data_sram_responder

Overview:
Slave (responder) end of the data-SRAM request/response interface that the memory pipeline consumes. It accepts requests from the execute/memory side through a req/addr_ok handshake and returns results through data_ok/rdata. It is backed by a word-addressed RAM with byte strobes, a 2-entry in-order outstanding queue, and configurable address-accept and data-return delays. It serves as the synthesizable data-memory model for the CPU top and as the test target for the pipeline's memory-access path.

Parameters:
DEPTH_LOG2, 10, RAM depth is 2^DEPTH_LOG2 words of 32 bits.
ADDR_OK_DELAY, 0, cycles a pending req must wait before addr_ok rises (0 to 7).
DATA_OK_DELAY, 1, cycles from acceptance, or from the previous response if later, to data_ok (1 to 7).

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
data_sram_req  in  1  request valid; held high until accepted.
data_sram_wr  in  1  1 = write, 0 = read.
data_sram_size  in  2  0 = byte, 1 = half, 2 = word; informational only, the strobes govern the write.
data_sram_addr  in  32  byte address; word index is addr[DEPTH_LOG2+1:2].
data_sram_wstrb  in  4  byte write enables; bit i enables wdata[8i+7:8i].
data_sram_wdata  in  32  write data.
data_sram_addr_ok  out  1  request accepted this cycle when it is high together with req.
data_sram_data_ok  out  1  one-cycle pulse marking the response for the oldest accepted request.
data_sram_rdata  out  32  read data, valid only when data_ok is high.

Behaviour:
- Handshake: a request is accepted in any cycle where req && addr_ok are both high. The master holds req, wr, size, addr, wstrb and wdata stable until acceptance.
- addr_ok is combinational: (count < 2) && (wait_cnt == ADDR_OK_DELAY).
  - count is the number of queue entries, sampled before any retire in the same cycle. A full queue therefore blocks acceptance even in a cycle where data_ok fires.
- wait_cnt (3 bits):
  - Increments each cycle that req is high, the queue is not full, and wait_cnt < ADDR_OK_DELAY.
  - Clears to 0 on acceptance.
  - Holds otherwise; it does not clear while req is low.
- Write, on the acceptance edge: each RAM byte whose strobe bit is 1 takes the matching wdata byte. Bytes with a 0 strobe keep their value. addr[1:0] is ignored; alignment checking belongs to the execute stage.
- Read, on the acceptance edge: the full RAM word is captured into the queue entry. Capture happens after any earlier writes, so a read-after-write returns the new data.
- Queue: 2-entry FIFO, each entry holds {wr, data} plus a 3-bit age counter. Responses are returned strictly in acceptance order.
- Response timing: the head entry issues data_ok in the cycle DATA_OK_DELAY cycles after the later of (a) its acceptance cycle or (b) the previous data_ok cycle.
  - With DATA_OK_DELAY = 1 this gives one response per cycle back-to-back.
  - data_ok and rdata are registered outputs. rdata is the captured word for reads and 0x00000000 for writes.
  - The head entry pops on the edge that ends its data_ok cycle.
- Simultaneous accept and retire while count = 1: count stays 1 and the new entry becomes head next cycle, aging from its own acceptance cycle.
- Reset values: data_ok = 0, rdata = 0, count = 0, wait_cnt = 0, all ages = 0. addr_ok is therefore high during reset iff ADDR_OK_DELAY == 0; requests presented during reset are not accepted.
- Reset mid-operation: outstanding entries are dropped and no data_ok is issued for them. RAM contents are not cleared, so completed writes persist.
- data_ok is never high in two consecutive cycles for the same entry. It never fires when the queue is empty.

Test Plan:
1. DATA_OK_DELAY=1: write 0xDEADBEEF to 0x10 with wstrb 1111, accepted in cycle T. Expect data_ok at T+1 with rdata 0. Read 0x10, accepted in cycle T+2. Expect data_ok at T+3 with rdata 0xDEADBEEF.
2. Byte write 0x0000AB00 to 0x10 with wstrb 0010, then read 0x10 -> rdata 0xDEADABEF.
3. Preload 0x14 with 0x12345678. Issue back-to-back reads of 0x10 and 0x14 at T and T+1 -> addr_ok high both cycles. data_ok at T+1 (0xDEADABEF) and T+2 (0x12345678), in order.
4. DATA_OK_DELAY=3, three consecutive reads held from T:
   - Accepts at T and T+1; addr_ok low T+2..T+3.
   - data_ok at T+3; third read accepted at T+4.
   - Remaining responses at T+6 and T+9.
5. ADDR_OK_DELAY=2, req held from T -> addr_ok low at T and T+1, high at T+2 (accepted). data_ok at T+3. wait_cnt is 0 at T+3.
6. Read accepted at T, reset asserted in cycle T+1 -> data_ok stays 0 through T+3. After reset, reading 0x10 returns the previously written 0xDEADABEF.

Source files
------------

// File: rtl/data_sram_responder.sv
// Data-SRAM responder: byte-strobed word RAM behind a req/addr_ok, data_ok/rdata
// handshake, with a 2-deep in-order response queue and programmable delays.
module data_sram_responder #(
  parameter int unsigned DEPTH_LOG2    = 10,
  parameter int unsigned ADDR_OK_DELAY = 0,
  parameter int unsigned DATA_OK_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam logic [2:0] AOK_DLY = 3'(ADDR_OK_DELAY);
  localparam logic [3:0] DOK_DLY = 4'(DATA_OK_DELAY);
  localparam logic       DOK_ONE = (DATA_OK_DELAY == 1);

  logic [31:0]           ram [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           new_data;

  logic [1:0]  count;
  logic [2:0]  wait_cnt;
  logic        q_wr   [2];
  logic [31:0] q_data [2];
  logic [2:0]  q_age  [2];

  logic        accept;
  logic        pop;
  logic [1:0]  slot;
  logic        fire;
  logic [31:0] rdata_nxt;

  logic unused_bits;
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:DEPTH_LOG2+2],
                         data_sram_addr[1:0], q_wr[0], q_wr[1]};

  assign idx               = data_sram_addr[DEPTH_LOG2+1:2];
  assign data_sram_addr_ok = (count < 2'd2) && (wait_cnt == AOK_DLY);
  assign accept            = data_sram_req && data_sram_addr_ok && !reset;
  assign pop               = data_sram_data_ok;
  assign new_data          = data_sram_wr ? '0 : ram[idx];
  assign slot              = count - {1'b0, pop};

  // Decide whether the entry that will be head next cycle responds then.
  // After a retire the next head's reference is the retire cycle, so it can
  // only fire immediately when the delay is one.
  always_comb begin
    fire      = 1'b0;
    rdata_nxt = '0;
    if (data_sram_data_ok) begin
      if (count == 2'd2) begin
        fire      = DOK_ONE;
        rdata_nxt = q_data[1];
      end else if (accept) begin
        fire      = DOK_ONE;
        rdata_nxt = new_data;
      end
    end else if (count != 2'd0) begin
      fire      = ({1'b0, q_age[0]} + 4'd1) == DOK_DLY;
      rdata_nxt = q_data[0];
    end else if (accept) begin
      fire      = DOK_ONE;
      rdata_nxt = new_data;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) ram[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count             <= '0;
      wait_cnt          <= '0;
      data_sram_data_ok <= 1'b0;
      data_sram_rdata   <= '0;
      q_age[0]          <= '0;
      q_age[1]          <= '0;
      q_wr[0]           <= 1'b0;
      q_wr[1]           <= 1'b0;
      q_data[0]         <= '0;
      q_data[1]         <= '0;
    end else begin
      data_sram_data_ok <= fire;
      data_sram_rdata   <= fire ? rdata_nxt : '0;
      count             <= count + {1'b0, accept} - {1'b0, pop};

      if (accept)
        wait_cnt <= '0;
      else if (data_sram_req && (count < 2'd2) && (wait_cnt < AOK_DLY))
        wait_cnt <= wait_cnt + 3'd1;

      // Pop shifts entry 1 to head; ages saturate at 7.
      if (pop) begin
        q_wr[0]   <= q_wr[1];
        q_data[0] <= q_data[1];
        q_age[0]  <= 3'd1;
      end else begin
        q_age[0] <= (&q_age[0]) ? q_age[0] : q_age[0] + 3'd1;
      end
      q_age[1] <= (&q_age[1]) ? q_age[1] : q_age[1] + 3'd1;

      if (accept) begin
        q_wr[slot[0]]   <= data_sram_wr;
        q_data[slot[0]] <= new_data;
        q_age[slot[0]]  <= 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: three instances cover the default
// timing, a long data-return delay and a non-zero address-accept delay.
module tb_data_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [3];
  logic        req   [3];
  logic        wr    [3];
  logic [1:0]  sz    [3];
  logic [31:0] addr  [3];
  logic [3:0]  strb  [3];
  logic [31:0] wdata [3];
  logic        aok   [3];
  logic        dok   [3];
  logic [31:0] rdata [3];

  int n_cmp = 0;
  int n_err = 0;

  data_sram_responder #(.DEPTH_LOG2(10), .ADDR_OK_DELAY(0), .DATA_OK_DELAY(1)) u_d1 (
    .clk(clk), .reset(rst[0]), .data_sram_req(req[0]), .data_sram_wr(wr[0]),
    .data_sram_size(sz[0]), .data_sram_addr(addr[0]), .data_sram_wstrb(strb[0]),
    .data_sram_wdata(wdata[0]), .data_sram_addr_ok(aok[0]),
    .data_sram_data_ok(dok[0]), .data_sram_rdata(rdata[0]));

  data_sram_responder #(.DEPTH_LOG2(10), .ADDR_OK_DELAY(0), .DATA_OK_DELAY(3)) u_d3 (
    .clk(clk), .reset(rst[1]), .data_sram_req(req[1]), .data_sram_wr(wr[1]),
    .data_sram_size(sz[1]), .data_sram_addr(addr[1]), .data_sram_wstrb(strb[1]),
    .data_sram_wdata(wdata[1]), .data_sram_addr_ok(aok[1]),
    .data_sram_data_ok(dok[1]), .data_sram_rdata(rdata[1]));

  data_sram_responder #(.DEPTH_LOG2(10), .ADDR_OK_DELAY(2), .DATA_OK_DELAY(1)) u_a2 (
    .clk(clk), .reset(rst[2]), .data_sram_req(req[2]), .data_sram_wr(wr[2]),
    .data_sram_size(sz[2]), .data_sram_addr(addr[2]), .data_sram_wstrb(strb[2]),
    .data_sram_wdata(wdata[2]), .data_sram_addr_ok(aok[2]),
    .data_sram_data_ok(dok[2]), .data_sram_rdata(rdata[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input int i, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    req[i] = r; wr[i] = w; addr[i] = a; strb[i] = s; wdata[i] = d; sz[i] = 2'd2;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt [10];
  logic [31:0] raddr [3];
  logic [31:0] rexp  [3];
  int          n_acc, n_resp;

  initial begin
    vt[0] = '{1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0};
    vt[1] = '{1'b0, 32'h10, 4'b0000, 32'h0,        32'hDEADBEEF};
    vt[2] = '{1'b1, 32'h10, 4'b0010, 32'h0000AB00, 32'h0};
    vt[3] = '{1'b0, 32'h10, 4'b0000, 32'h0,        32'hDEADABEF};
    vt[4] = '{1'b1, 32'h14, 4'b1111, 32'h12345678, 32'h0};
    vt[5] = '{1'b0, 32'h14, 4'b0000, 32'h0,        32'h12345678};
    vt[6] = '{1'b1, 32'h18, 4'b1111, 32'h11223344, 32'h0};
    vt[7] = '{1'b1, 32'h18, 4'b1100, 32'hAABB0000, 32'h0};
    vt[8] = '{1'b1, 32'h1B, 4'b0001, 32'h000000EE, 32'h0};
    vt[9] = '{1'b0, 32'h18, 4'b0000, 32'h0,        32'hAABB33EE};

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      drive(i, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    end
    // A request presented during reset must not be taken.
    drive(0, 1'b1, 1'b1, 32'h14, 4'hF, 32'h55555555);
    cyc(); cyc(); settle();
    chk("reset_aok_d0", 32'(aok[0]), 32'd1);
    chk("reset_aok_d2", 32'(aok[2]), 32'd0);
    chk("reset_dok",    32'(dok[0]), 32'd0);
    chk("reset_rdata",  rdata[0],    32'h0);
    cyc();
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    settle();
    cyc(); settle();
    chk("no_resp_for_reset_req", 32'(dok[0]), 32'd0);

    // Single transactions, one-cycle return.
    for (int v = 0; v < 10; v++) begin
      cyc();
      drive(0, 1'b1, vt[v].wr, vt[v].addr, vt[v].strb, vt[v].wdata);
      settle();
      chk($sformatf("vec%0d_aok", v), 32'(aok[0]), 32'd1);
      cyc();
      drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      settle();
      chk($sformatf("vec%0d_dok", v), 32'(dok[0]), 32'd1);
      chk($sformatf("vec%0d_rdata", v), rdata[0], vt[v].exp);
      cyc(); settle();
      chk($sformatf("vec%0d_dok_once", v), 32'(dok[0]), 32'd0);
    end

    // Back-to-back reads, one response per cycle.
    cyc();
    drive(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    settle();
    chk("b2b_aok0", 32'(aok[0]), 32'd1);
    cyc();
    drive(0, 1'b1, 1'b0, 32'h14, 4'h0, 32'h0);
    settle();
    chk("b2b_aok1",   32'(aok[0]), 32'd1);
    chk("b2b_dok1",   32'(dok[0]), 32'd1);
    chk("b2b_rdata1", rdata[0],    32'hDEADABEF);
    cyc();
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    settle();
    chk("b2b_dok2",   32'(dok[0]), 32'd1);
    chk("b2b_rdata2", rdata[0],    32'h12345678);
    cyc(); settle();
    chk("b2b_idle", 32'(dok[0]), 32'd0);

    // Preload the delay-3 instance.
    raddr[0] = 32'h0; raddr[1] = 32'h4; raddr[2] = 32'h8;
    rexp[0] = 32'hA0A0A0A0; rexp[1] = 32'hB1B1B1B1; rexp[2] = 32'hC2C2C2C2;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k < 3) drive(1, 1'b1, 1'b1, raddr[k], 4'hF, rexp[k]);
      else       drive(1, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADABEF);
      cyc();
      drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      repeat (5) cyc();
    end

    // Three held reads against a full two-entry queue.
    n_acc = 0; n_resp = 0;
    for (int c = 0; c <= 10; c++) begin
      cyc();
      drive(1, n_acc < 3, 1'b0, (n_acc < 3) ? raddr[n_acc] : 32'h0, 4'h0, 32'h0);
      settle();
      if (c <= 4) chk($sformatf("d3_aok_c%0d", c), 32'(aok[1]), (c == 2 || c == 3) ? 32'd0 : 32'd1);
      chk($sformatf("d3_dok_c%0d", c), 32'(dok[1]), (c == 3 || c == 6 || c == 9) ? 32'd1 : 32'd0);
      if (dok[1] && n_resp < 3) begin
        chk($sformatf("d3_rdata%0d", n_resp), rdata[1], rexp[n_resp]);
        n_resp++;
      end
      if (req[1] && aok[1]) n_acc++;
    end
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // Address-accept delay of 2: write, then an immediately held read.
    cyc();
    drive(2, 1'b1, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D);
    settle();
    chk("a2_aok_t0", 32'(aok[2]), 32'd0);
    cyc(); settle();
    chk("a2_aok_t1", 32'(aok[2]), 32'd0);
    cyc(); settle();
    chk("a2_aok_t2", 32'(aok[2]), 32'd1);
    cyc();
    drive(2, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    settle();
    chk("a2_aok_t3",   32'(aok[2]), 32'd0);
    chk("a2_dok_t3",   32'(dok[2]), 32'd1);
    chk("a2_rdata_t3", rdata[2],    32'h0);
    cyc(); settle();
    chk("a2_aok_t4", 32'(aok[2]), 32'd0);
    cyc(); settle();
    chk("a2_aok_t5", 32'(aok[2]), 32'd1);
    cyc();
    drive(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    settle();
    chk("a2_dok_t6",   32'(dok[2]), 32'd1);
    chk("a2_rdata_t6", rdata[2],    32'hCAFEF00D);

    // Reset with a read outstanding drops it; RAM contents survive.
    cyc();
    drive(1, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    settle();
    chk("rst_aok", 32'(aok[1]), 32'd1);
    cyc();
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst[1] = 1'b1;
    settle();
    chk("rst_dok_t1", 32'(dok[1]), 32'd0);
    cyc();
    rst[1] = 1'b0;
    settle();
    chk("rst_dok_t2", 32'(dok[1]), 32'd0);
    cyc(); settle();
    chk("rst_dok_t3", 32'(dok[1]), 32'd0);
    cyc(); settle();
    chk("rst_dok_t4", 32'(dok[1]), 32'd0);
    cyc();
    drive(1, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    settle();
    chk("post_rst_aok", 32'(aok[1]), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      settle();
      chk($sformatf("post_rst_dok_k%0d", k), 32'(dok[1]), (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) chk("post_rst_rdata", rdata[1], 32'hDEADABEF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
